// File: rtl/cplx_mul_pkg.sv
// Shared constants and width helpers for the pipelined complex multiplier.
package cplx_mul_pkg;

    localparam int DEF_W      = 16;
    localparam int DEF_FRAC   = 14;
    localparam int PIPE_DEPTH = 3;

    // Width of the post-add sums that feed rounding/saturation.
    function automatic int rs_width(input int w);
        return 2 * w + 3;
    endfunction

endpackage

// File: rtl/cplx_mul_pipe_if.sv
// Operand/result stream bundle for cplx_mul_pipe (valid/ready on both sides).
interface cplx_mul_pipe_if
    import cplx_mul_pkg::*;
#(
    parameter int W = DEF_W
) ();

    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] a_re;
    logic signed [W-1:0] a_im;
    logic signed [W-1:0] b_re;
    logic signed [W-1:0] b_im;
    logic                conj;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] c_re;
    logic signed [W-1:0] c_im;
    logic                sat;

    modport master (
        output in_valid, a_re, a_im, b_re, b_im, conj, out_ready,
        input  in_ready, out_valid, c_re, c_im, sat
    );

    modport slave (
        input  in_valid, a_re, a_im, b_re, b_im, conj, out_ready,
        output in_ready, out_valid, c_re, c_im, sat
    );

endinterface

// File: rtl/cplx_round_sat.sv
// Round-half-up by FRAC bits then clamp one wide post-add sum to W bits.
module cplx_round_sat
    import cplx_mul_pkg::*;
#(
    parameter int W    = DEF_W,
    parameter int FRAC = DEF_FRAC
) (
    input  logic signed [rs_width(W)-1:0] din,
    output logic signed [W-1:0]           dout,
    output logic                          clip
);

    localparam int RW = rs_width(W);

    localparam logic signed [W-1:0]  OMAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0]  OMIN = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [RW:0]   MAXV = (RW+1)'(OMAX);
    localparam logic signed [RW:0]   MINV = (RW+1)'(OMIN);
    localparam logic signed [RW:0]   HALF = (RW+1)'(64'd1 << (FRAC-1));

    // One guard bit above the sum so adding HALF can never wrap.
    function automatic logic signed [RW:0] round_hu(input logic signed [RW-1:0] v);
        logic signed [RW:0] ve;
        logic signed [RW:0] vs;
        ve = (RW+1)'(v);
        vs = ve + HALF;
        return vs >>> FRAC;
    endfunction

    function automatic logic [W:0] sat_w(input logic signed [RW:0] r);
        if (r > MAXV)
            return {1'b1, OMAX};
        else if (r < MINV)
            return {1'b1, OMIN};
        else
            return {1'b0, r[W-1:0]};
    endfunction

    always_comb begin
        {clip, dout} = sat_w(round_hu(din));
    end

endmodule

// File: rtl/cplx_mul_pipe.sv
// Three-stage complex multiplier (Gauss 3-mult form) with a shared stall enable.
module cplx_mul_pipe
    import cplx_mul_pkg::*;
#(
    parameter int W    = DEF_W,
    parameter int FRAC = DEF_FRAC
) (
    input logic             clk,
    input logic             rst_n,
    cplx_mul_pipe_if.slave  bus
);

    localparam int PW = W + 1;
    localparam int MW = 2 * W + 2;
    localparam int RW = rs_width(W);

    logic en;

    logic signed [PW-1:0] x_p0, y_p0, l_p0, m_p0, mc_p0;
    logic signed [PW-1:0] lmm_p0, lpm_p0, xmy_p0;

    logic signed [PW-1:0] lmm_p1, lpm_p1, xmy_p1, x_p1, y_p1, l_p1;
    logic                 vld_p1;

    logic signed [MW-1:0] t1_p2, t2_p2, t3_p2;
    logic                 vld_p2;

    logic signed [RW-1:0] re_sum_p2, im_sum_p2;
    logic signed [W-1:0]  re_rnd_p2, im_rnd_p2;
    logic                 re_clip_p2, im_clip_p2;

    // A full output slot that nobody takes freezes the whole pipe, bubbles too.
    assign en           = ~bus.out_valid | bus.out_ready;
    assign bus.in_ready = en;

    // ---- S1: widen, conditional negate of M, pre-adds ----
    always_comb begin
        x_p0   = PW'(bus.a_re);
        y_p0   = PW'(bus.a_im);
        l_p0   = PW'(bus.b_re);
        m_p0   = PW'(bus.b_im);
        mc_p0  = bus.conj ? -m_p0 : m_p0;
        lmm_p0 = l_p0 - mc_p0;
        lpm_p0 = l_p0 + mc_p0;
        xmy_p0 = x_p0 - y_p0;
    end

    always_ff @(posedge clk) begin
        if (en) begin
            lmm_p1 <= lmm_p0;
            lpm_p1 <= lpm_p0;
            xmy_p1 <= xmy_p0;
            x_p1   <= x_p0;
            y_p1   <= y_p0;
            l_p1   <= l_p0;
        end
    end

    // ---- S2: three signed multiplies ----
    always_ff @(posedge clk) begin
        if (en) begin
            t1_p2 <= MW'(lmm_p1) * MW'(y_p1);
            t2_p2 <= MW'(lpm_p1) * MW'(x_p1);
            t3_p2 <= MW'(xmy_p1) * MW'(l_p1);
        end
    end

    // ---- S3: post-adds, round, saturate, registered output ----
    always_comb begin
        re_sum_p2 = RW'(t1_p2) + RW'(t3_p2);
        im_sum_p2 = RW'(t2_p2) - RW'(t3_p2);
    end

    cplx_round_sat #(.W(W), .FRAC(FRAC)) u_rs_re (
        .din  (re_sum_p2),
        .dout (re_rnd_p2),
        .clip (re_clip_p2)
    );

    cplx_round_sat #(.W(W), .FRAC(FRAC)) u_rs_im (
        .din  (im_sum_p2),
        .dout (im_rnd_p2),
        .clip (im_clip_p2)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1        <= 1'b0;
            vld_p2        <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.c_re      <= '0;
            bus.c_im      <= '0;
            bus.sat       <= 1'b0;
        end else if (en) begin
            vld_p1        <= bus.in_valid;
            vld_p2        <= vld_p1;
            bus.out_valid <= vld_p2;
            bus.c_re      <= re_rnd_p2;
            bus.c_im      <= im_rnd_p2;
            bus.sat       <= re_clip_p2 | im_clip_p2;
        end
    end

endmodule

// File: tb/tb_cplx_mul_pipe.sv
// Bench for cplx_mul_pipe: vector table, stall/reset sequences, random stream vs scoreboard.
module tb_cplx_mul_pipe;
    import cplx_mul_pkg::*;

    localparam int W    = 16;
    localparam int FRAC = 14;

    typedef struct {
        int ar, ai, br, bi;
        bit cj;
        int er, ei;
        bit es;
    } vec_t;

    typedef struct {
        int re, im;
        bit sat;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    cplx_mul_pipe_if #(.W(W)) bus ();

    cplx_mul_pipe #(.W(W), .FRAC(FRAC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   pushes   = 0;
    bit   chk_lat  = 1'b1;
    bit   hold_pend = 1'b0;
    logic signed [W-1:0] hold_re, hold_im;
    logic hold_sat;
    exp_t exp_next;
    exp_t sb[$];
    vec_t vt[10];

    task automatic check_eq(input string nm, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic int rnd_sat(input longint v, output bit s);
        longint r;
        r = (v + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
        s = 1'b0;
        if (r > 32767) begin r = 32767; s = 1'b1; end
        if (r < -32768) begin r = -32768; s = 1'b1; end
        return int'(r);
    endfunction

    // Direct 4-multiply reference, deliberately not the Gauss arrangement.
    function automatic exp_t model(input int ar, ai, br, bi, input bit cj);
        exp_t   e;
        longint x, y, l, m, re, im;
        bit     s1, s2;
        x = ar; y = ai; l = br; m = bi;
        if (cj) m = -m;
        re = x * l - m * y;
        im = x * m + y * l;
        e.re  = rnd_sat(re, s1);
        e.im  = rnd_sat(im, s2);
        e.sat = s1 | s2;
        e.cyc = 0;
        return e;
    endfunction

    function automatic int rand_op();
        logic signed [W-1:0] r;
        case ($urandom_range(0, 15))
            0: return -32768;
            1: return 32767;
            2: return 16384;
            3: return -16384;
            default: begin
                r = W'($urandom);
                return int'(r);
            end
        endcase
    endfunction

    task automatic drive(input int ar, ai, br, bi, input bit cj);
        bus.a_re = W'(ar);
        bus.a_im = W'(ai);
        bus.b_re = W'(br);
        bus.b_im = W'(bi);
        bus.conj = cj;
    endtask

    task automatic drive_rand();
        int ar, ai, br, bi;
        bit cj;
        ar = rand_op(); ai = rand_op(); br = rand_op(); bi = rand_op();
        cj = 1'($urandom);
        drive(ar, ai, br, bi, cj);
        exp_next = model(ar, ai, br, bi, cj);
    endtask

    // One clock: observe handshakes that the coming edge completes, then move to the next negedge.
    task automatic step();
        exp_t e;
        #1;
        check_eq("in_ready", longint'(bus.in_ready), longint'(!bus.out_valid || bus.out_ready));
        if (hold_pend) begin
            check_eq("hold_valid", longint'(bus.out_valid), 1);
            check_eq("hold_re", longint'(bus.c_re), longint'(hold_re));
            check_eq("hold_im", longint'(bus.c_im), longint'(hold_im));
            check_eq("hold_sat", longint'(bus.sat), longint'(hold_sat));
        end
        hold_pend = bus.out_valid && !bus.out_ready;
        hold_re   = bus.c_re;
        hold_im   = bus.c_im;
        hold_sat  = bus.sat;
        if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output actual=out_valid required=no beat outstanding (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                check_eq("c_re", longint'(bus.c_re), e.re);
                check_eq("c_im", longint'(bus.c_im), e.im);
                check_eq("sat", longint'(bus.sat), e.sat);
                if (chk_lat) check_eq("latency", cyc - e.cyc, PIPE_DEPTH);
            end
        end
        if (bus.in_valid && bus.in_ready) begin
            e     = exp_next;
            e.cyc = cyc;
            sb.push_back(e);
            pushes++;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain(input string nm);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 40 && sb.size() > 0; k++) step();
        repeat (3) step();
        check_eq(nm, sb.size(), 0);
    endtask

    initial begin
        int n0, start, guard;
        bit pending;

        vt[0] = '{8192, 8192, 8192, -8192, 1'b0, 8192, 0, 1'b0};
        vt[1] = '{0, 16384, 0, 16384, 1'b1, 16384, 0, 1'b0};
        vt[2] = '{0, 16384, 0, 16384, 1'b0, -16384, 0, 1'b0};
        vt[3] = '{-32768, 0, -32768, 0, 1'b0, 32767, 0, 1'b1};
        vt[4] = '{1, 0, 8192, 0, 1'b0, 1, 0, 1'b0};
        vt[5] = '{-32768, 0, 32767, 0, 1'b0, -32768, 0, 1'b1};
        vt[6] = '{0, 16384, 0, -32768, 1'b1, -32768, 0, 1'b0};
        vt[7] = '{-3, 0, 8192, 0, 1'b0, -1, 0, 1'b0};
        vt[8] = '{16384, 16384, 16384, 16384, 1'b0, 0, 32767, 1'b1};
        vt[9] = '{1000, -2000, 3000, 4000, 1'b0, 671, -122, 1'b0};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive(0, 0, 0, 0, 1'b0);
        exp_next = '{0, 0, 1'b0, 0};
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_out_valid", longint'(bus.out_valid), 0);
        check_eq("rst_c_re", longint'(bus.c_re), 0);
        check_eq("rst_c_im", longint'(bus.c_im), 0);
        check_eq("rst_sat", longint'(bus.sat), 0);
        check_eq("rst_in_ready", longint'(bus.in_ready), 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Table vectors, one isolated beat each, exact latency checked.
        for (int i = 0; i < 10; i++) begin
            drive(vt[i].ar, vt[i].ai, vt[i].br, vt[i].bi, vt[i].cj);
            exp_next = '{vt[i].er, vt[i].ei, vt[i].es, 0};
            bus.in_valid = 1'b1;
            step();
            bus.in_valid = 1'b0;
            repeat (4) step();
        end
        check_eq("table_drain", sb.size(), 0);

        // Backpressure: three back-to-back beats, 5-cycle stall, a fourth beat waiting.
        chk_lat = 1'b0;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive_rand();
            step();
        end
        drive_rand();
        bus.out_ready = 1'b0;
        #1;
        check_eq("bp_first_valid", longint'(bus.out_valid), 1);
        for (int k = 0; k < 5; k++) begin
            #1;
            check_eq("bp_in_ready", longint'(bus.in_ready), 0);
            step();
        end
        bus.out_ready = 1'b1;
        step();
        drain("bp_drain");

        // Reset with one beat at the output and two in flight.
        chk_lat = 1'b1;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(vt[9 - (k % 2)].ar, vt[9 - (k % 2)].ai, vt[9 - (k % 2)].br,
                  vt[9 - (k % 2)].bi, vt[9 - (k % 2)].cj);
            exp_next = '{vt[9 - (k % 2)].er, vt[9 - (k % 2)].ei, vt[9 - (k % 2)].es, 0};
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        check_eq("pre_rst_valid", longint'(bus.out_valid), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_out_valid", longint'(bus.out_valid), 0);
        check_eq("midrst_c_re", longint'(bus.c_re), 0);
        check_eq("midrst_c_im", longint'(bus.c_im), 0);
        check_eq("midrst_sat", longint'(bus.sat), 0);
        sb.delete();
        hold_pend = 1'b0;
        @(negedge clk);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        drive(vt[3].ar, vt[3].ai, vt[3].br, vt[3].bi, vt[3].cj);
        exp_next = '{vt[3].er, vt[3].ei, vt[3].es, 0};
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        repeat (6) step();
        check_eq("post_rst_drain", sb.size(), 0);

        // Random stream with random stalls on both sides.
        chk_lat = 1'b0;
        start   = pushes;
        guard   = 0;
        pending = 1'b0;
        while ((pushes - start) < 10000 && guard < 60000) begin
            if (!pending) begin
                bus.in_valid = ($urandom_range(0, 9) < 7);
                if (bus.in_valid) drive_rand();
            end
            bus.out_ready = ($urandom_range(0, 9) < 7);
            n0 = pushes;
            step();
            pending = bus.in_valid && (pushes == n0);
            guard++;
        end
        check_eq("rand_beats_accepted", pushes - start, 10000);
        drain("rand_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
